// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  localparam int BYTE_W          = 8;
  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_TIMEOUT_CYC = 16;
  localparam int DEF_MAX_BURST   = 8;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin search: first valid requester at or after ptr, wrapping.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int W = $clog2(NUM_REQ);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && valid[j]) begin
        any    = 1'b1;
        idx    = W'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte sources.
// Optional burst hold per requester is compiled in with UART_TX_SCHED_BURST_EN.
//
// state       | meaning
// S_IDLE      | no frame in flight; grant when enabled, requested and tx idle
// S_LOAD      | one-cycle tx_wr_en strobe with the latched byte
// S_WAIT_BUSY | waiting for tx_busy to rise, bounded by TIMEOUT_CYC
// S_WAIT_DONE | frame in progress, waiting for tx_busy to fall
module uart_tx_scheduler import uart_pkg::*; #(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`ifdef UART_TX_SCHED_BURST_EN
  , parameter int MAX_BURST = DEF_MAX_BURST
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
`ifdef UART_TX_SCHED_BURST_EN
  input  logic [NUM_REQ-1:0]          req_last,
`endif
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [BYTE_W-1:0]           tx_din,
  output logic                        tx_wr_en,
  output logic                        tx_clken,
  input  logic                        tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        sched_busy,
  output logic                        timeout_err
);

  localparam int W     = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t             state, state_nxt;
  logic [W-1:0]       ptr;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_clr, cnt_inc, grant_take;
  logic [NUM_REQ-1:0] arb_gnt, win_onehot;
  logic [W-1:0]       arb_idx, win_idx, ptr_adv;
  logic               arb_any, win_any;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid (req_valid),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .any   (arb_any)
  );

`ifdef UART_TX_SCHED_BURST_EN
  localparam int BCNT_W = $clog2(MAX_BURST + 1);
  logic              hold;
  logic [BCNT_W-1:0] burst_cnt;

  // While a burst is held only the owner is eligible; everyone else waits.
  always_comb begin
    if (hold) begin
      win_any    = req_valid[grant_id];
      win_idx    = grant_id;
      win_onehot = NUM_REQ'(1) << grant_id;
    end else begin
      win_any    = arb_any;
      win_idx    = arb_idx;
      win_onehot = arb_gnt;
    end
  end
`else
  assign win_any    = arb_any;
  assign win_idx    = arb_idx;
  assign win_onehot = arb_gnt;
`endif

  assign ptr_adv = (win_idx == W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    tx_wr_en    = 1'b0;
    tx_clken    = 1'b0;
    timeout_err = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    grant_take  = 1'b0;
    sched_busy  = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        // rst_n gate keeps req_ready low while reset is held.
        if (rst_n && en && win_any && !tx_busy) begin
          grant_take = 1'b1;
          req_ready  = win_onehot;
          state_nxt  = S_LOAD;
        end
      end
      S_LOAD: begin
        tx_wr_en  = 1'b1;
        tx_clken  = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        tx_clken = 1'b1;
        if (tx_busy) begin
          state_nxt = S_WAIT_DONE;
        end else if (cnt == CNT_W'(TIMEOUT_CYC)) begin
          timeout_err = 1'b1;
          tx_clken    = 1'b0;
          state_nxt   = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        tx_clken = 1'b1;
        if (!tx_busy) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      tx_din    <= '0;
      grant_id  <= '0;
`ifdef UART_TX_SCHED_BURST_EN
      hold      <= 1'b0;
      burst_cnt <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (grant_take) begin
        tx_din   <= req_data[win_idx*BYTE_W +: BYTE_W];
        grant_id <= win_idx;
`ifdef UART_TX_SCHED_BURST_EN
        if (!req_last[win_idx] && ((burst_cnt + 1'b1) < BCNT_W'(MAX_BURST))) begin
          hold      <= 1'b1;
          burst_cnt <= burst_cnt + 1'b1;
        end else begin
          hold      <= 1'b0;
          burst_cnt <= '0;
          ptr       <= ptr_adv;
        end
`else
        ptr <= ptr_adv;
`endif
      end
    end
  end

endmodule
